// File: rtl/ram2_arbiter_if.sv
// Bundles the IF/EXE request ports and the RAM2 controller handshake of the arbiter.
interface ram2_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              exe_rd;
    logic              exe_wr;
    logic [ADDR_W-1:0] exe_addr;
    logic [DATA_W-1:0] exe_wdata;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              exe_done;
    logic [DATA_W-1:0] exe_rdata;
    logic              if_stall;
    logic              exe_stall;
    logic              ram_req;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [DATA_W-1:0] ram_rdata;
    logic              timeout_err;

    // Arbiter side: serves the pipeline stages and masters the RAM2 bus
    modport master (
        input  if_req, if_addr, exe_rd, exe_wr, exe_addr, exe_wdata, ram_ack, ram_rdata,
        output if_done, if_rdata, exe_done, exe_rdata, if_stall, exe_stall,
        output ram_req, ram_wr, ram_addr, ram_wdata, timeout_err
    );

    // Environment side: pipeline stages plus RAM2 controller
    modport slave (
        output if_req, if_addr, exe_rd, exe_wr, exe_addr, exe_wdata, ram_ack, ram_rdata,
        input  if_done, if_rdata, exe_done, exe_rdata, if_stall, exe_stall,
        input  ram_req, ram_wr, ram_addr, ram_wdata, timeout_err
    );
endinterface

// File: rtl/ram2_arbiter.sv
// Single-port RAM2 access scheduler: EXE priority with IF anti-starvation,
// one transaction at a time on a req/ack handshake, watchdog abort on a hung ack.
module ram2_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned TIMEOUT      = 255
) (
    input logic           clk,
    input logic           rst,
    ram2_arbiter_if.master bus
);
    localparam int unsigned SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WD_W = 8;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_GRANT_IF  = 2'd1;
    localparam logic [1:0] S_GRANT_EXE = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]        state,       state_nxt;
    logic              ram_req_q,   ram_req_nxt;
    logic              ram_wr_q,    ram_wr_nxt;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_nxt;
    logic              if_done_q,   if_done_nxt;
    logic              exe_done_q,  exe_done_nxt;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_nxt;
    logic [DATA_W-1:0] exe_rdata_q, exe_rdata_nxt;
    logic              tmo_q,       tmo_nxt;
    logic [SC_W-1:0]   starve_q,    starve_nxt;
    logic [WD_W-1:0]   wdog_q,      wdog_nxt;

    logic exe_req;
    logic exe_ok;
    logic finish;
    logic [DATA_W-1:0] fin_data;

    assign exe_req = bus.exe_rd | bus.exe_wr;
    assign exe_ok  = exe_req & (~bus.if_req | (starve_q < SC_W'(STARVE_LIMIT)));

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ram_req_q   <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_done_q   <= 1'b0;
            exe_done_q  <= 1'b0;
            if_rdata_q  <= '0;
            exe_rdata_q <= '0;
            tmo_q       <= 1'b0;
            starve_q    <= '0;
            wdog_q      <= '0;
        end else begin
            state       <= state_nxt;
            ram_req_q   <= ram_req_nxt;
            ram_wr_q    <= ram_wr_nxt;
            ram_addr_q  <= ram_addr_nxt;
            ram_wdata_q <= ram_wdata_nxt;
            if_done_q   <= if_done_nxt;
            exe_done_q  <= exe_done_nxt;
            if_rdata_q  <= if_rdata_nxt;
            exe_rdata_q <= exe_rdata_nxt;
            tmo_q       <= tmo_nxt;
            starve_q    <= starve_nxt;
            wdog_q      <= wdog_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        ram_req_nxt   = ram_req_q;
        ram_wr_nxt    = ram_wr_q;
        ram_addr_nxt  = ram_addr_q;
        ram_wdata_nxt = ram_wdata_q;
        if_done_nxt   = 1'b0;
        exe_done_nxt  = 1'b0;
        if_rdata_nxt  = if_rdata_q;
        exe_rdata_nxt = exe_rdata_q;
        tmo_nxt       = tmo_q;
        starve_nxt    = starve_q;
        wdog_nxt      = wdog_q;
        finish        = 1'b0;
        fin_data      = '1;

        case (state)
            S_IDLE: begin
                if (exe_ok) begin
                    state_nxt     = S_GRANT_EXE;
                    ram_req_nxt   = 1'b1;
                    ram_wr_nxt    = bus.exe_wr;
                    ram_addr_nxt  = bus.exe_addr;
                    ram_wdata_nxt = bus.exe_wdata;
                    wdog_nxt      = '0;
                    if (!bus.if_req) begin
                        starve_nxt = '0;
                    end else if (starve_q < SC_W'(STARVE_LIMIT)) begin
                        starve_nxt = starve_q + SC_W'(1);
                    end
                end else if (bus.if_req) begin
                    state_nxt    = S_GRANT_IF;
                    ram_req_nxt  = 1'b1;
                    ram_wr_nxt   = 1'b0;
                    ram_addr_nxt = bus.if_addr;
                    wdog_nxt     = '0;
                    starve_nxt   = '0;
                end
            end
            S_GRANT_IF, S_GRANT_EXE: begin
                // A coincident ack wins over the watchdog limit
                if (bus.ram_ack) begin
                    finish   = 1'b1;
                    fin_data = bus.ram_rdata;
                end else if (wdog_q == WD_W'(TIMEOUT)) begin
                    finish  = 1'b1;
                    tmo_nxt = 1'b1;
                end else begin
                    wdog_nxt = wdog_q + WD_W'(1);
                end
                if (finish) begin
                    state_nxt   = S_DONE;
                    ram_req_nxt = 1'b0;
                    if (state == S_GRANT_IF) begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = fin_data;
                    end else begin
                        exe_done_nxt  = 1'b1;
                        exe_rdata_nxt = fin_data;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt   = S_IDLE;
                ram_req_nxt = 1'b0;
            end
        endcase
    end

    assign bus.ram_req     = ram_req_q;
    assign bus.ram_wr      = ram_wr_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.if_done     = if_done_q;
    assign bus.exe_done    = exe_done_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.exe_rdata   = exe_rdata_q;
    assign bus.timeout_err = tmo_q;
    assign bus.if_stall    = bus.if_req & ~if_done_q;
    assign bus.exe_stall   = exe_req & ~exe_done_q;
endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed bench for ram2_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_ram2_arbiter;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    ram2_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    ram2_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(3), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        exe_rd;
        logic        exe_wr;
        logic [15:0] exe_addr;
        logic [15:0] exe_wdata;
        logic        ram_ack;
        logic [15:0] ram_rdata;
        logic        e_req;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        chk_wd;
        logic        e_if_done;
        logic        e_exe_done;
        logic        e_if_stall;
        logic        e_exe_stall;
        logic [15:0] e_if_rdata;
        logic [15:0] e_exe_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic add(input logic ir, input logic [15:0] ia, input logic rd, input logic wr,
                       input logic [15:0] ea, input logic [15:0] ewd, input logic ack,
                       input logic [15:0] rdat, input logic rq, input logic rw,
                       input logic [15:0] ra, input logic [15:0] rwd, input logic cwd,
                       input logic ifd, input logic exd, input logic ifs, input logic exs,
                       input logic [15:0] ifr, input logic [15:0] exr);
        vec_t v;
        v = '{ir, ia, rd, wr, ea, ewd, ack, rdat, rq, rw, ra, rwd, cwd, ifd, exd, ifs, exs, ifr, exr};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic rd, input logic wr,
                         input logic [15:0] ea, input logic [15:0] ewd);
        bus.if_req    = ir;
        bus.if_addr   = ia;
        bus.exe_rd    = rd;
        bus.exe_wr    = wr;
        bus.exe_addr  = ea;
        bus.exe_wdata = ewd;
    endtask

    // Bounded wait for ram_req at a falling edge
    task automatic wait_req(input string nm, output logic seen);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.ram_req) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic seen;
        int   cnt;

        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = 16'h0;
        #1;
        chk("rst.ram_req",     32'(bus.ram_req),     32'd0);
        chk("rst.ram_wr",      32'(bus.ram_wr),      32'd0);
        chk("rst.ram_addr",    32'(bus.ram_addr),    32'd0);
        chk("rst.ram_wdata",   32'(bus.ram_wdata),   32'd0);
        chk("rst.if_done",     32'(bus.if_done),     32'd0);
        chk("rst.exe_done",    32'(bus.exe_done),    32'd0);
        chk("rst.if_rdata",    32'(bus.if_rdata),    32'd0);
        chk("rst.exe_rdata",   32'(bus.exe_rdata),   32'd0);
        chk("rst.timeout_err", 32'(bus.timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        //   ir ia       rd wr ea       ewd      ak rdat      rq rw ra       rwd      cw ifd exd ifs exs ifr      exr
        add(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        add(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        add(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        add(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h1234, 16'h0000);
        add(0, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h1234, 16'h0000);
        add(0, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 16'hDEAD, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h1234, 16'h0000);
        add(1, 16'h0020, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 1, 0, 0, 1, 1, 16'h1234, 16'h0000);
        add(1, 16'h0020, 1, 1, 16'h9999, 16'h1111, 0, 16'h0000, 1, 1, 16'h8000, 16'hBEEF, 1, 0, 0, 1, 1, 16'h1234, 16'h0000);
        add(1, 16'h0020, 1, 1, 16'h9999, 16'h1111, 1, 16'h5555, 0, 0, 16'h0000, 16'hBEEF, 1, 0, 1, 1, 0, 16'h1234, 16'h5555);
        add(1, 16'h0020, 0, 0, 16'h9999, 16'h1111, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h1234, 16'h5555);
        add(1, 16'h0020, 0, 0, 16'h9999, 16'h1111, 0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 0, 0, 0, 1, 0, 16'h1234, 16'h5555);
        add(1, 16'h0020, 0, 0, 16'h9999, 16'h1111, 1, 16'hABCD, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'hABCD, 16'h5555);
        add(0, 16'h0020, 0, 0, 16'h9999, 16'h1111, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'hABCD, 16'h5555);
        add(0, 16'h0000, 1, 0, 16'h0042, 16'h7777, 0, 16'h0000, 1, 0, 16'h0042, 16'h7777, 1, 0, 0, 0, 1, 16'hABCD, 16'h5555);
        add(0, 16'h0000, 1, 0, 16'h0042, 16'h7777, 1, 16'h0F0F, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'hABCD, 16'h0F0F);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'hABCD, 16'h0F0F);

        foreach (vecs[i]) begin
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].exe_rd, vecs[i].exe_wr,
                  vecs[i].exe_addr, vecs[i].exe_wdata);
            bus.ram_ack   = vecs[i].ram_ack;
            bus.ram_rdata = vecs[i].ram_rdata;
            @(negedge clk);
            chk($sformatf("v%0d.ram_req", i), 32'(bus.ram_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d.ram_wr", i),   32'(bus.ram_wr),   32'(vecs[i].e_wr));
                chk($sformatf("v%0d.ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].e_addr));
            end
            if (vecs[i].chk_wd)
                chk($sformatf("v%0d.ram_wdata", i), 32'(bus.ram_wdata), 32'(vecs[i].e_wdata));
            chk($sformatf("v%0d.if_done", i),   32'(bus.if_done),   32'(vecs[i].e_if_done));
            chk($sformatf("v%0d.exe_done", i),  32'(bus.exe_done),  32'(vecs[i].e_exe_done));
            chk($sformatf("v%0d.if_stall", i),  32'(bus.if_stall),  32'(vecs[i].e_if_stall));
            chk($sformatf("v%0d.exe_stall", i), 32'(bus.exe_stall), 32'(vecs[i].e_exe_stall));
            chk($sformatf("v%0d.if_rdata", i),  32'(bus.if_rdata),  32'(vecs[i].e_if_rdata));
            chk($sformatf("v%0d.exe_rdata", i), 32'(bus.exe_rdata), 32'(vecs[i].e_exe_rdata));
            chk($sformatf("v%0d.timeout_err", i), 32'(bus.timeout_err), 32'd0);
        end
        bus.ram_ack = 1'b0;

        // Both stages held, immediate acks: EXE,EXE,EXE,IF repeating
        drive(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, 16'h0);
        for (int g = 0; g < 8; g++) begin
            logic is_if;
            is_if = (g % 4) == 3;
            wait_req($sformatf("starve%0d.req_seen", g), seen);
            if (seen) begin
                chk($sformatf("starve%0d.ram_addr", g), 32'(bus.ram_addr),
                    is_if ? 32'h0100 : 32'h0200);
                bus.ram_ack   = 1'b1;
                bus.ram_rdata = 16'(g);
                @(negedge clk);
                bus.ram_ack = 1'b0;
                chk($sformatf("starve%0d.if_done", g),  32'(bus.if_done),  32'(is_if));
                chk($sformatf("starve%0d.exe_done", g), 32'(bus.exe_done), 32'(!is_if));
            end
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);

        // Watchdog abort on a load that never gets an ack
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0300, 16'h0);
        wait_req("wdog.req_seen", seen);
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cnt++;
            if (bus.exe_done || bus.if_done) break;
        end
        chk("wdog.cycles",      32'(cnt),             32'd256);
        chk("wdog.exe_done",    32'(bus.exe_done),    32'd1);
        chk("wdog.if_done",     32'(bus.if_done),     32'd0);
        chk("wdog.exe_rdata",   32'(bus.exe_rdata),   32'hFFFF);
        chk("wdog.timeout_err", 32'(bus.timeout_err), 32'd1);
        chk("wdog.ram_req",     32'(bus.ram_req),     32'd0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);

        // timeout_err stays sticky across a good fetch
        drive(1'b1, 16'h0500, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_req("sticky.req_seen", seen);
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 16'h2468;
        @(negedge clk);
        bus.ram_ack = 1'b0;
        chk("sticky.if_done",     32'(bus.if_done),     32'd1);
        chk("sticky.if_rdata",    32'(bus.if_rdata),    32'h2468);
        chk("sticky.timeout_err", 32'(bus.timeout_err), 32'd1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);

        // Reset while a fetch is granted, then the held request is re-granted
        drive(1'b1, 16'h0400, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_req("rstmid.req_seen", seen);
        #2 rst = 1'b0;
        #1;
        chk("rstmid.ram_req",     32'(bus.ram_req),     32'd0);
        chk("rstmid.if_done",     32'(bus.if_done),     32'd0);
        chk("rstmid.timeout_err", 32'(bus.timeout_err), 32'd0);
        @(negedge clk);
        chk("rstmid.if_done_low", 32'(bus.if_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_req("rstmid.regrant", seen);
        chk("rstmid.ram_addr", 32'(bus.ram_addr), 32'h0400);
        chk("rstmid.ram_wr",   32'(bus.ram_wr),   32'd0);
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 16'hAAAA;
        @(negedge clk);
        bus.ram_ack = 1'b0;
        chk("rstmid.done",     32'(bus.if_done),  32'd1);
        chk("rstmid.if_rdata", 32'(bus.if_rdata), 32'hAAAA);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
